// File: rtl/axil_uart_ctrl_if.sv
// AXI4-Lite bus bundle between an interconnect master and the UART controller slave.
// Ports (per modport):
//   master: drives AW/W/AR address, data and valids plus BREADY/RREADY
//   slave : drives AWREADY/WREADY/ARREADY, B and R responses
interface axil_uart_ctrl_if #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axil_uart_ctrl.sv
// AXI4-Lite slave that maps the UART FIFOs and enables onto four registers
// (addr[3:2]: 0 RX, 1 TX, 2 STAT, 3 CTRL) and turns bus accesses into one-cycle
// FIFO push/pop strobes. Also raises a one-cycle Interrupt on RX-not-empty rising
// or TX-full falling when interrupts are enabled.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN : clock, async active-low reset
//   s_axi                     : AXI4-Lite slave bundle
//   RX_data, Empty, Full      : RX FIFO head / empty flag, TX FIFO full flag
//   rd_uart_en                : RX FIFO pop strobe
//   TX_data, wr_uart_en       : TX FIFO push data and strobe
//   Enable_rx, Enable_tx      : UART receiver / transmitter enables
//   Interrupt                 : one-cycle interrupt pulse
module axil_uart_ctrl #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_DATA_BITS        = 8
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  axil_uart_ctrl_if.slave        s_axi,
  output logic                   Interrupt,
  input  logic [C_DATA_BITS-1:0] RX_data,
  input  logic                   Empty,
  input  logic                   Full,
  output logic                   rd_uart_en,
  output logic [C_DATA_BITS-1:0] TX_data,
  output logic                   wr_uart_en,
  output logic                   Enable_rx,
  output logic                   Enable_tx
);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] AddrRx     = 2'd0;
  localparam logic [1:0] AddrTx     = 2'd1;
  localparam logic [1:0] AddrStat   = 2'd2;
  localparam logic [1:0] AddrCtrl   = 2'd3;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e r_wstate, w_wstate_next;
  rstate_e r_rstate, w_rstate_next;
  logic    w_wr_hs, w_rd_hs;

  logic [1:0]                    r_bresp, r_rresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [C_DATA_BITS-1:0]        r_tx_data;
  logic                          r_wr_en, r_rd_en;
  logic [2:0]                    r_ctrl;      // {intr_en, Enable_rx, Enable_tx}
  logic                          r_not_empty, r_full, r_irq;
  logic                          w_edge;

  logic [1:0] w_waddr, w_raddr;
  assign w_waddr = s_axi.S_AXI_AWADDR[3:2];
  assign w_raddr = s_axi.S_AXI_ARADDR[3:2];

  logic w_unused;
  assign w_unused = ^{s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0],
                      s_axi.S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:C_DATA_BITS],
                      s_axi.S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1]};

  // Write FSM: AWREADY/WREADY only in the cycle both valids are present. Gated by
  // reset so no handshake is offered while reset is asserted.
  always_comb begin
    w_wstate_next = r_wstate;
    w_wr_hs       = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        if (S_AXI_ARESETN && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
          w_wr_hs       = 1'b1;
          w_wstate_next = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) w_wstate_next = W_IDLE;
      end
    endcase
  end

  // Read FSM
  always_comb begin
    w_rstate_next = r_rstate;
    w_rd_hs       = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        if (S_AXI_ARESETN && s_axi.S_AXI_ARVALID) begin
          w_rd_hs       = 1'b1;
          w_rstate_next = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) w_rstate_next = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_next;
      r_rstate <= w_rstate_next;
    end
  end

  // Write side: push strobe is set at the handshake so it lines up with BVALID rising.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_bresp   <= RespOkay;
      r_tx_data <= '0;
      r_wr_en   <= 1'b0;
      r_ctrl    <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_wr_hs) begin
        r_bresp <= RespOkay;
        case (w_waddr)
          AddrTx: begin
            if (Full) begin
              r_bresp <= RespSlverr;
            end else if (s_axi.S_AXI_WSTRB[0]) begin
              r_tx_data <= s_axi.S_AXI_WDATA[C_DATA_BITS-1:0];
              r_wr_en   <= 1'b1;
            end
          end
          AddrCtrl: begin
            if (s_axi.S_AXI_WSTRB[0]) begin
              r_ctrl <= {s_axi.S_AXI_WDATA[4], s_axi.S_AXI_WDATA[1], s_axi.S_AXI_WDATA[0]};
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read side: data and response are captured at the AR handshake.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_rdata <= '0;
      r_rresp <= RespOkay;
      r_rd_en <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      if (w_rd_hs) begin
        r_rdata <= '0;
        r_rresp <= RespOkay;
        case (w_raddr)
          AddrRx: begin
            if (!Empty) begin
              r_rdata[C_DATA_BITS-1:0] <= RX_data;
              r_rd_en                  <= 1'b1;
            end else begin
              r_rresp <= RespSlverr;
            end
          end
          AddrStat: r_rdata[4:0] <= {r_ctrl[2], Full, 2'b00, !Empty};
          AddrCtrl: r_rdata[4:0] <= {r_ctrl[2], 2'b00, r_ctrl[1], r_ctrl[0]};
          default: ;
        endcase
      end
    end
  end

  // Edge detect: a simultaneous RX-ready rise and TX-full fall yields one pulse.
  assign w_edge = (!Empty && !r_not_empty) || (!Full && r_full);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_not_empty <= 1'b0;
      r_full      <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_not_empty <= !Empty;
      r_full      <= Full;
      r_irq       <= r_ctrl[2] && w_edge;
    end
  end

  assign s_axi.S_AXI_AWREADY = w_wr_hs;
  assign s_axi.S_AXI_WREADY  = w_wr_hs;
  assign s_axi.S_AXI_BVALID  = (r_wstate == W_RESP);
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_ARREADY = w_rd_hs;
  assign s_axi.S_AXI_RVALID  = (r_rstate == R_DATA);
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;

  assign TX_data    = r_tx_data;
  assign wr_uart_en = r_wr_en;
  assign rd_uart_en = r_rd_en;
  assign Enable_tx  = r_ctrl[0];
  assign Enable_rx  = r_ctrl[1];
  assign Interrupt  = r_irq;
endmodule
